// File: rtl/envelope_shaper_if.sv
// Note/sample stream between the player and the envelope shaper.
// The master drives notes and samples; the slave returns scaled samples.
interface envelope_shaper_if #(
    parameter int SAMPLE_W = 16,
    parameter int DUR_W    = 6
);
    logic                       note_start;
    logic [DUR_W-1:0]           note_duration;
    logic                       generate_next_sample;
    logic signed [SAMPLE_W-1:0] sample;
    logic signed [SAMPLE_W-1:0] final_sample;
    logic                       sample_valid;

    modport master (
        output note_start,
        output note_duration,
        output generate_next_sample,
        output sample,
        input  final_sample,
        input  sample_valid
    );

    modport slave (
        input  note_start,
        input  note_duration,
        input  generate_next_sample,
        input  sample,
        output final_sample,
        output sample_valid
    );
endinterface

// File: rtl/envelope_shaper.sv
// ADSR amplitude envelope applied to a signed sample stream.
// Define DYNAMICS_EXP_DECAY_EN for exponential decay/release.
module envelope_shaper #(
    parameter int SAMPLE_W  = 16,
    parameter int ENV_W     = 8,
    parameter int DUR_W     = 6,
    parameter int DUR_SHIFT = 4
) (
    input  logic             clk,
    input  logic             reset,
    envelope_shaper_if.slave io,
    input  logic [ENV_W-1:0] attack_rate,
    input  logic [ENV_W-1:0] decay_rate,
    input  logic [ENV_W-1:0] sustain_level,
    input  logic [ENV_W-1:0] release_rate,
    output logic [2:0]       env_state,
    output logic             busy
);
    localparam int GATE_W = DUR_W + DUR_SHIFT;
    localparam logic [ENV_W-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                     state, state_nxt;
    logic [ENV_W-1:0]           env, env_nxt;
    logic [GATE_W-1:0]          gate_cnt, gate_nxt;
    logic signed [SAMPLE_W-1:0] out_q;
    logic                       valid_q;

    logic                       tick;
    logic                       gated;
    logic [GATE_W-1:0]          gate_load;
    logic [ENV_W:0]             att_sum;
    logic [ENV_W:0]             dec_amt;
    logic [ENV_W:0]             rel_amt;
    logic [ENV_W:0]             dec_gap;
    logic signed [SAMPLE_W+ENV_W:0] prod;
    logic signed [SAMPLE_W-1:0] scaled;

    assign tick      = io.generate_next_sample;
    assign gated     = (state == ATTACK) || (state == DECAY) ||
                       (state == SUSTAIN);
    assign gate_load = GATE_W'(io.note_duration) << DUR_SHIFT;
    assign att_sum   = {1'b0, env} + {1'b0, attack_rate};
    assign dec_gap   = {1'b0, env - sustain_level};

`ifdef DYNAMICS_EXP_DECAY_EN
    // Step shrinks with the level; the +1 guarantees it still reaches the target.
    assign dec_amt = (int'(decay_rate) >= ENV_W) ? '0 :
                     {1'b0, env >> decay_rate} + {{ENV_W{1'b0}}, 1'b1};
    assign rel_amt = (int'(release_rate) >= ENV_W) ? '0 :
                     {1'b0, env >> release_rate} + {{ENV_W{1'b0}}, 1'b1};
`else
    assign dec_amt = {1'b0, decay_rate};
    assign rel_amt = {1'b0, release_rate};
`endif

    // Zero-extended envelope keeps the product signed; env < 2^ENV_W cannot overflow.
    assign prod   = $signed(io.sample) * $signed({1'b0, env});
    assign scaled = SAMPLE_W'(prod >>> ENV_W);

    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        gate_nxt  = gate_cnt;
        if (io.note_start) begin
            state_nxt = ATTACK;
            gate_nxt  = gate_load;
        end else if (tick) begin
            if (gate_cnt != '0)
                gate_nxt = gate_cnt - 1'b1;
            if (gated && (gate_cnt == '0)) begin
                state_nxt = RELEASE;
            end else begin
                unique case (state)
                    ATTACK: begin
                        if ((attack_rate == '0) ||
                            (att_sum >= {1'b0, ENV_MAX})) begin
                            env_nxt   = ENV_MAX;
                            state_nxt = DECAY;
                        end else begin
                            env_nxt = att_sum[ENV_W-1:0];
                        end
                    end
                    DECAY: begin
                        if ((env <= sustain_level) ||
                            (dec_amt >= dec_gap)) begin
                            env_nxt   = sustain_level;
                            state_nxt = SUSTAIN;
                        end else begin
                            env_nxt = env - dec_amt[ENV_W-1:0];
                        end
                    end
                    SUSTAIN: env_nxt = sustain_level;
                    RELEASE: begin
                        if (rel_amt >= {1'b0, env}) begin
                            env_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            env_nxt = env - rel_amt[ENV_W-1:0];
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            env      <= '0;
            gate_cnt <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            env      <= env_nxt;
            gate_cnt <= gate_nxt;
            valid_q  <= tick;
            if (tick)
                out_q <= scaled;
        end
    end

    assign io.final_sample = out_q;
    assign io.sample_valid = valid_q;
    assign env_state       = state;
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_envelope_shaper.sv
// Directed bench for envelope_shaper; sample=256 reads the envelope back 1:1.
// Expected values adapt when DYNAMICS_EXP_DECAY_EN is defined.
module tb_envelope_shaper;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] attack_rate;
    logic [7:0] decay_rate;
    logic [7:0] sustain_level;
    logic [7:0] release_rate;
    logic [2:0] env_state;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef DYNAMICS_EXP_DECAY_EN
    localparam int REL_T4 = 1;
    localparam int ENV_T4 = 127;
    localparam int R1 = 149, R2 = 111, R3 = 83;
`else
    localparam int REL_T4 = 159;
    localparam int ENV_T4 = 96;
    localparam int R1 = 198, R2 = 196, R3 = 194;
`endif

    always #5 clk = ~clk;

    envelope_shaper_if sif ();

    envelope_shaper dut (
        .clk           (clk),
        .reset         (reset),
        .io            (sif.slave),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .env_state     (env_state),
        .busy          (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic tick(input int s);
        @(negedge clk);
        sif.generate_next_sample = 1'b1;
        sif.sample = 16'(s);
        @(negedge clk);
        sif.generate_next_sample = 1'b0;
    endtask

    task automatic ticks(input int n, input int s);
        repeat (n) tick(s);
    endtask

    task automatic start(input int dur);
        @(negedge clk);
        sif.note_start = 1'b1;
        sif.note_duration = 6'(dur);
        @(negedge clk);
        sif.note_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rates(input int a, input int d, input int s, input int r);
        attack_rate   = 8'(a);
        decay_rate    = 8'(d);
        sustain_level = 8'(s);
        release_rate  = 8'(r);
    endtask

    function automatic int fs();
        return int'(sif.final_sample);
    endfunction

    initial begin
        reset = 1'b1;
        sif.note_start = 1'b0;
        sif.note_duration = '0;
        sif.generate_next_sample = 1'b1;
        sif.sample = 16'sd1000;
        rates(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_state", int'(env_state), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out", fs(), 0);
        check("rst_valid", int'(sif.sample_valid), 0);
        sif.generate_next_sample = 1'b0;
        reset = 1'b0;

        // idle ticks still produce (zero) samples
        tick(1000);
        check("idle_valid", int'(sif.sample_valid), 1);
        check("idle_out", fs(), 0);
        check("idle_state", int'(env_state), 0);
        @(negedge clk);
        check("valid_pulse", int'(sif.sample_valid), 0);

`ifndef DYNAMICS_EXP_DECAY_EN
        // full ADSR cycle
        do_reset();
        rates(64, 16, 128, 32);
        start(2);
        check("adsr_att", int'(env_state), 1);
        check("adsr_busy", int'(busy), 1);
        tick(256);
        check("adsr_t1", fs(), 0);
        tick(256);
        check("adsr_t2", fs(), 64);
        ticks(2, 256);
        check("adsr_t4", fs(), 192);
        check("adsr_dec", int'(env_state), 2);
        tick(256);
        check("adsr_t5", fs(), 255);
        ticks(7, 256);
        check("adsr_t12", fs(), 143);
        check("adsr_sus", int'(env_state), 3);
        tick(256);
        check("adsr_t13", fs(), 128);
        ticks(19, 256);
        check("adsr_t32", int'(env_state), 3);
        tick(256);
        check("adsr_rel", int'(env_state), 4);
        tick(1000);
        check("adsr_1000", fs(), 500);
        tick(256);
        check("adsr_t35", fs(), 96);
        ticks(2, 256);
        check("adsr_t37", fs(), 32);
        check("adsr_idle", int'(env_state), 0);
        check("adsr_nbusy", int'(busy), 0);
        tick(256);
        check("adsr_t38", fs(), 0);
`endif

        // full-scale scaling and instant attack
        do_reset();
        rates(0, 0, 255, 0);
        start(63);
        tick(256);
        check("inst_state", int'(env_state), 2);
        tick(-32768);
        check("fs_neg", fs(), -32640);
        check("fs_sus", int'(env_state), 3);
        tick(32767);
        check("fs_pos", fs(), 32639);
        tick(-1);
        check("fs_m1", fs(), -1);

        // reset in the middle of DECAY
        do_reset();
        rates(0, 1, 0, 0);
        start(63);
        ticks(2, 256);
        check("md_dec", int'(env_state), 2);
        check("md_out", fs(), 255);
        @(negedge clk);
        reset = 1'b1;
        sif.generate_next_sample = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sif.generate_next_sample = 1'b0;
        check("md_state", int'(env_state), 0);
        check("md_out0", fs(), 0);
        check("md_valid", int'(sif.sample_valid), 0);
        check("md_busy", int'(busy), 0);

        // retrigger during RELEASE keeps the level
        do_reset();
        rates(96, 0, 255, REL_T4);
        start(1);
        ticks(17, 256);
        check("rt_rel", int'(env_state), 4);
        tick(256);
        attack_rate = 8'd200;
        start(1);
        check("rt_att", int'(env_state), 1);
        tick(256);
        check("rt_keep", fs(), ENV_T4);
        check("rt_dec", int'(env_state), 2);
        tick(256);
        check("rt_max", fs(), 255);
        ticks(14, 256);
        check("rt_gate", int'(env_state), 3);
        tick(256);
        check("rt_rel2", int'(env_state), 4);

        // start and tick together, zero-length note
        do_reset();
        rates(50, 0, 0, 0);
        @(negedge clk);
        sif.note_start = 1'b1;
        sif.note_duration = '0;
        sif.generate_next_sample = 1'b1;
        sif.sample = 16'sd256;
        @(negedge clk);
        sif.note_start = 1'b0;
        sif.generate_next_sample = 1'b0;
        check("st_valid", int'(sif.sample_valid), 1);
        check("st_out", fs(), 0);
        check("st_state", int'(env_state), 1);
        tick(256);
        check("d0_rel", int'(env_state), 4);
        check("d0_out", fs(), 0);
        tick(256);
        check("d0_env", fs(), 0);
        check("d0_idle", int'(env_state), 0);

        // release shape from a live sustain level of 200
        do_reset();
        rates(200, 0, 255, 2);
        start(1);
        ticks(3, 256);
        check("ex_sus", int'(env_state), 3);
        sustain_level = 8'd200;
        tick(256);
        check("ex_t4", fs(), 255);
        ticks(12, 256);
        check("ex_t16", fs(), 200);
        tick(256);
        check("ex_rel", int'(env_state), 4);
        tick(256);
        check("ex_t18", fs(), 200);
        tick(256);
        check("ex_r1", fs(), R1);
        tick(256);
        check("ex_r2", fs(), R2);
        tick(256);
        check("ex_r3", fs(), R3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
